frame_geometry: RTL
===================

# frame_geometry

Parametrised frame-size measurement block that supersedes the separate width and height counters in the Hough pipeline. It monitors the `FrameIn`/`LineIn` timing of the incoming pixel stream and measures active line length and line count per frame. It checks every line of a frame for consistent length and publishes `Width`/`Height` only after the same geometry has been seen for a configurable number of consecutive clean frames. Edge, Resize and Circle consume `Width`/`Height`/`Locked`.

## Interface
- `W_BITS`, default 8: width of the pixel-per-line counter and the `Width` output.
- `H_BITS`, default 8: width of the line-per-frame counter and the `Height` output.
- `LOCK_FRAMES`, default 2: consecutive identical clean frames required to lock (1..15).

- `Clk`  in  1  single clock; all logic is on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `FrameIn`  in  1  high for the whole active frame.
- `LineIn`  in  1  high for each active pixel of a line.
- `Width`  out  W_BITS  locked pixels per line; reset 0.
- `Height`  out  H_BITS  locked lines per frame; reset 0.
- `Locked`  out  1  `Width`/`Height` valid and current; reset 0.
- `LineErr`  out  1  one-cycle pulse on a line whose length differs from the frame's first line; reset 0.
- `Overflow`  out  1  sticky; a counter saturated; reset 0; cleared only by `nReset`.

## Operation
- Registered delays `FrameIn_d` and `LineIn_d`.
- Frame start: `FrameIn & !FrameIn_d`. Frame end: `!FrameIn & FrameIn_d`.
- Line end: `LineIn_d & !LineIn`, or frame end while `LineIn_d` is 1.
- FSM states:
  - IDLE: waiting for a frame. Goes to FRAME on frame start, which clears per-frame state (`wcnt`, `hcnt`, `ref_w`, `first`, `bad`).
  - FRAME: counting. Goes to EVAL on frame end.
  - EVAL: lasts exactly 1 cycle. Goes to FRAME if a frame start is seen in that cycle (per-frame state cleared), otherwise to IDLE.
- `LineIn` is ignored outside FRAME.
- In FRAME, each cycle with `LineIn`=1 increments `wcnt`, saturating at 2^W_BITS−1.
- Any attempted increment past the maximum sets `Overflow` and `bad`. The same rule applies to `hcnt`.
- On each line end:
  - `hcnt`++.
  - On the first line of the frame, `ref_w` ← line length.
  - On later lines, a length ≠ `ref_w` sets `bad` and pulses `LineErr`.
  - `wcnt` ← 0.
- EVAL decision, using frame geometry (`ref_w`, `hcnt`):
  - Reject if `bad`=1 or `hcnt`=0: `match` ← 0, `Locked` ← 0.
  - Else if the geometry equals the candidate (`cand_w`, `cand_h`) and `match` ≠ 0: `match` ← min(`match`+1, 15).
  - Else: candidate ← geometry, `match` ← 1.
  - Lock: if the resulting `match` ≥ LOCK_FRAMES, then `Width` ← `cand_w`, `Height` ← `cand_h`, `Locked` ← 1. Otherwise `Locked` ← 0.
- `Width`/`Height` keep their last locked values while `Locked`=0. They never return to 0 except via reset.
- A rejected or changed-geometry frame drops `Locked` at that frame's EVAL.
- Relock requires LOCK_FRAMES fresh identical clean frames.
- A reset mid-frame discards all state. A frame already in progress when reset is released is ignored, because it starts without a rising edge.

## Timing
- Edge t is the first edge sampling `FrameIn`=0 after 1. The FSM enters EVAL at edge t, and `Width`/`Height`/`Locked` update at edge t+1.
- `LineErr` goes high at the edge that samples `LineIn`=0 ending the bad line, and stays high for exactly 1 cycle.
- `Overflow` sets at the edge of the saturating increment.
- Minimum inter-frame gap is 1 cycle (`FrameIn` low for one sample); a rising `FrameIn` during EVAL is not lost.
- A minimum gap of 1 cycle between lines is required for the lines to be counted separately.
- `LineErr` and the frame-end closure of an open line may fire in the same cycle as frame end. The line is counted before EVAL.

## Test plan
- Reset: hold `nReset`=0 with random inputs → all outputs 0. Release mid-frame → that frame is ignored and `Locked` stays 0.
- Default params, 3 frames of 4 lines × 6 pixels, gaps of 2 cycles → `Locked` rises at edge t+1 of frame 2 with `Width`=6, `Height`=4, and stays 1 after frame 3.
- Locked at 6×4, next frame has line 3 of 5 pixels → `LineErr` is a 1-cycle pulse at that line end, `Locked`=0 after that frame's EVAL, `Width`/`Height` hold 6/4.
- Geometry change to 8×3 for 2 frames with a 1-cycle inter-frame gap → `Locked` drops after the first 8×3 frame, then relocks with 8/3 after the second.
- W_BITS=3, one line of 9 pixels → `Overflow`=1 at the 8th increment and stays 1. Frame rejected, `Locked`=0, `Width` unchanged.
- `FrameIn` falls while `LineIn`=1 on the 4th line of a 6×4 frame → the line is closed and counted, giving `Height`=4 and no `LineErr`.

Source files
------------

// File: rtl/frame_geometry.sv
// frame_geometry: measures active pixels per line and lines per frame from the
// FrameIn/LineIn timing, checks every line against the first line of the frame
// and publishes Width/Height once the same geometry has been seen on
// LOCK_FRAMES consecutive clean frames.
module frame_geometry #(
    parameter int W_BITS      = 8,
    parameter int H_BITS      = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              FrameIn,
    input  logic              LineIn,
    output logic [W_BITS-1:0] Width,
    output logic [H_BITS-1:0] Height,
    output logic              Locked,
    output logic              LineErr,
    output logic              Overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_EVAL  = 2'd2;

    localparam logic [3:0] LOCK_THR  = 4'(LOCK_FRAMES);
    localparam logic [3:0] MATCH_MAX = 4'd15;

    logic              r_frame_d;
    logic              r_line_d;
    logic [1:0]        r_state;
    logic [W_BITS-1:0] r_wcnt;
    logic [W_BITS-1:0] r_ref_w;
    logic [H_BITS-1:0] r_hcnt;
    logic              r_first;
    logic              r_bad;
    logic [W_BITS-1:0] r_cand_w;
    logic [H_BITS-1:0] r_cand_h;
    logic [3:0]        r_match;
    logic [W_BITS-1:0] r_width;
    logic [H_BITS-1:0] r_height;
    logic              r_locked;
    logic              r_line_err;
    logic              r_overflow;

    logic              w_frame_start;
    logic              w_frame_end;
    logic              w_line_end;
    logic              w_in_frame;
    logic              w_pix;
    logic              w_w_ovf;
    logic              w_h_ovf;
    logic              w_len_err;
    logic              w_reject;
    logic              w_same;
    logic              w_lock;
    logic [3:0]        w_match_next;
    logic [W_BITS-1:0] w_cand_w_next;
    logic [H_BITS-1:0] w_cand_h_next;

    assign w_frame_start = FrameIn & ~r_frame_d;
    assign w_frame_end   = ~FrameIn & r_frame_d;
    // A line also closes when the frame ends underneath it.
    assign w_line_end    = (r_line_d & ~LineIn) | (w_frame_end & r_line_d);
    assign w_in_frame    = (r_state == S_FRAME);
    // A LineIn sample taken after FrameIn has dropped lies outside the frame,
    // so it closes the line but does not add a pixel.
    assign w_pix         = w_in_frame & LineIn & FrameIn;
    assign w_w_ovf       = w_pix & (&r_wcnt);
    assign w_h_ovf       = w_in_frame & w_line_end & (&r_hcnt);
    assign w_len_err     = w_in_frame & w_line_end & ~r_first & (r_wcnt != r_ref_w);

    assign Width    = r_width;
    assign Height   = r_height;
    assign Locked   = r_locked;
    assign LineErr  = r_line_err;
    assign Overflow = r_overflow;

    // End-of-frame decision: reject, confirm the candidate, or adopt a new one.
    always_comb begin
        w_reject      = r_bad | (r_hcnt == '0);
        w_same        = (r_ref_w == r_cand_w) && (r_hcnt == r_cand_h) && (r_match != 4'd0);
        w_match_next  = r_match;
        w_cand_w_next = r_cand_w;
        w_cand_h_next = r_cand_h;
        if (w_reject) begin
            w_match_next = 4'd0;
        end else if (w_same) begin
            w_match_next = (r_match == MATCH_MAX) ? MATCH_MAX : r_match + 4'd1;
        end else begin
            w_cand_w_next = r_ref_w;
            w_cand_h_next = r_hcnt;
            w_match_next  = 4'd1;
        end
        w_lock = ~w_reject && (w_match_next >= LOCK_THR);
    end

    // Input delays for edge detection; FrameIn_d resets high so that a frame
    // already running at reset release never looks like a frame start.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_frame_d <= 1'b1;
            r_line_d  <= 1'b0;
        end else begin
            r_frame_d <= FrameIn;
            r_line_d  <= LineIn;
        end
    end

    // Frame FSM with per-frame pixel/line counting and line-length checking.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_hcnt  <= '0;
            r_ref_w <= '0;
            r_first <= 1'b1;
            r_bad   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= S_FRAME;
                        r_wcnt  <= '0;
                        r_hcnt  <= '0;
                        r_ref_w <= '0;
                        r_first <= 1'b1;
                        r_bad   <= 1'b0;
                    end
                end
                S_FRAME: begin
                    if (w_pix && !(&r_wcnt)) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    if (w_line_end) begin
                        if (!(&r_hcnt)) begin
                            r_hcnt <= r_hcnt + 1'b1;
                        end
                        if (r_first) begin
                            r_ref_w <= r_wcnt;
                            r_first <= 1'b0;
                        end
                        r_wcnt <= '0;
                    end
                    if (w_w_ovf || w_h_ovf || w_len_err) begin
                        r_bad <= 1'b1;
                    end
                    if (w_frame_end) begin
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_frame_start) begin
                        r_state <= S_FRAME;
                        r_wcnt  <= '0;
                        r_hcnt  <= '0;
                        r_ref_w <= '0;
                        r_first <= 1'b1;
                        r_bad   <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // LineErr pulse and sticky counter-saturation flag.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_line_err <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_line_err <= w_len_err;
            if (w_w_ovf || w_h_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Lock tracking; published geometry only changes when a lock is reached.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_cand_w <= '0;
            r_cand_h <= '0;
            r_match  <= 4'd0;
            r_width  <= '0;
            r_height <= '0;
            r_locked <= 1'b0;
        end else if (r_state == S_EVAL) begin
            r_cand_w <= w_cand_w_next;
            r_cand_h <= w_cand_h_next;
            r_match  <= w_match_next;
            r_locked <= w_lock;
            if (w_lock) begin
                r_width  <= w_cand_w_next;
                r_height <= w_cand_h_next;
            end
        end
    end

endmodule
